// File: rtl/psram_pkg.sv
// -----------------------------------------------------------------------------
// psram_pkg
// Shared definitions for the CellularRAM device-side responder:
//   - state_e     : responder bus-cycle states
//   - BCR_RESET   : reset value of the bus configuration register
//   - BCR_LAT_*   : bit positions of the read-latency field inside the BCR
//   - bcr_lat_m1  : read latency minus one, as encoded by a BCR value
// -----------------------------------------------------------------------------
package psram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WRITE,
        READ_LAT,
        READ_DRIVE
    } state_e;

    localparam int unsigned CRAM_ADDR_W = 22;

    localparam logic [15:0] BCR_RESET   = 16'h9D1F;
    localparam int unsigned BCR_LAT_MSB = 13;
    localparam int unsigned BCR_LAT_LSB = 11;

    // A latency field of 0 encodes 8 cycles, so latency-1 is 7 in that case.
    function automatic logic [3:0] bcr_lat_m1(input logic [15:0] bcr);
        logic [2:0] field;
        field = bcr[BCR_LAT_MSB:BCR_LAT_LSB];
        return (field == 3'd0) ? 4'd7 : {1'b0, field - 3'd1};
    endfunction

endpackage

// File: rtl/psram_word_array.sv
// -----------------------------------------------------------------------------
// psram_word_array
// Byte-masked single-port word array: synchronous write, combinational read.
// Ports:
//   clk      in   write clock
//   wr_en    in   commit wr_data at idx on the rising edge
//   wr_be    in   byte enables, [1] = bits 15:8, [0] = bits 7:0
//   idx      in   word index, shared by read and write
//   wr_data  in   write data
//   rd_data  out  word currently stored at idx
// -----------------------------------------------------------------------------
module psram_word_array #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [1:0]            wr_be,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [15:0]           wr_data,
    output logic [15:0]           rd_data
);

    logic [15:0] mem [2**ADDR_WIDTH];

    // NOTE: the storage has no reset; contents survive a reset like the real
    // chip, and a resettable array would not map onto RAM macros.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_be[1]) mem[idx][15:8] <= wr_data[15:8];
            if (wr_be[0]) mem[idx][7:0]  <= wr_data[7:0];
        end
    end

    assign rd_data = mem[idx];

endmodule

// File: rtl/psram_responder.sv
// -----------------------------------------------------------------------------
// psram_responder
// Device-side model of one CellularRAM bank on the asynchronous multiplexed
// address/data bus. The address is latched on ADV, then a write (WE) or a
// read (OE) is serviced from psram_word_array. Protocol violations raise a
// sticky protocol_err.
//
// Ports:
//   clk, reset          controller clock; asynchronous active-high reset
//   cram_a, cram_dq_in  address high bits / multiplexed address-data in
//   cram_dq_out/_oe     read data and its drive enable
//   cram_ce_n/adv_n/cre/we_n/oe_n/ub_n/lb_n   bus controls
//   cram_wait           busy during read latency (polarity WAIT_ACTIVE_HIGH)
//   protocol_err        sticky violation flag
//   write_count/read_count  wrapping transaction counters
//
// Optional feature: PSRAM_RESPONDER_BCR_EN enables the bus configuration
// register (written by cre=1 at ADV, supplies read latency, readable with cre).
// Without it cram_cre is ignored.
// -----------------------------------------------------------------------------
module psram_responder
    import psram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH       = 10,
    parameter int unsigned READ_LATENCY     = 3,
    parameter bit          WAIT_ACTIVE_HIGH = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  cram_a,
    input  logic [15:0] cram_dq_in,
    output logic [15:0] cram_dq_out,
    output logic        cram_dq_oe,
    input  logic        cram_ce_n,
    input  logic        cram_adv_n,
    input  logic        cram_cre,
    input  logic        cram_we_n,
    input  logic        cram_oe_n,
    input  logic        cram_ub_n,
    input  logic        cram_lb_n,
    output logic        cram_wait,
    output logic        protocol_err,
    output logic [15:0] write_count,
    output logic [15:0] read_count
);

    localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           hold_data_q, hold_data_d;
    logic                  hold_ub_n_q, hold_ub_n_d;
    logic                  hold_lb_n_q, hold_lb_n_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wait_q, wait_d;
    logic [15:0]           dq_out_q, dq_out_d;
    logic                  dq_oe_q, dq_oe_d;
    logic                  err_q, err_d;
    logic [15:0]           wcnt_q, wcnt_d;
    logic [15:0]           rcnt_q, rcnt_d;

    logic [CRAM_ADDR_W-1:0] adv_addr;
    logic                   adv_addr_unused_hi;
    logic                   sel;
    logic                   latch_addr;
    logic                   mem_we;
    logic [15:0]            rd_data;
    logic [15:0]            read_word;
    logic [3:0]             lat_m1;

    assign adv_addr           = {cram_a, cram_dq_in};
    assign adv_addr_unused_hi = ^adv_addr[CRAM_ADDR_W-1:ADDR_WIDTH];
    assign sel                = ~cram_ce_n;

`ifdef PSRAM_RESPONDER_BCR_EN
    logic        cre_q, cre_d;
    logic [15:0] bcr_q, bcr_d;
    assign lat_m1    = bcr_lat_m1(bcr_q);
    assign read_word = cre_q ? bcr_q : rd_data;
`else
    logic cre_unused;
    assign cre_unused = cram_cre;
    assign lat_m1     = LAT_M1;
    assign read_word  = rd_data;
`endif

    psram_word_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_be   ({~hold_ub_n_q, ~hold_lb_n_q}),
        .idx     (addr_q),
        .wr_data (hold_data_q),
        .rd_data (rd_data)
    );

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        hold_data_d = hold_data_q;
        hold_ub_n_d = hold_ub_n_q;
        hold_lb_n_d = hold_lb_n_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = dq_oe_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        latch_addr  = 1'b0;
        mem_we      = 1'b0;
`ifdef PSRAM_RESPONDER_BCR_EN
        cre_d       = cre_q;
        bcr_d       = bcr_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (sel && !cram_adv_n) begin
                    latch_addr = 1'b1;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (!sel) begin
                    state_d = IDLE;
                end else if (!cram_adv_n) begin
                    latch_addr = 1'b1;
                end else if (!cram_we_n) begin
                    hold_data_d = cram_dq_in;
                    hold_ub_n_d = cram_ub_n;
                    hold_lb_n_d = cram_lb_n;
                    state_d     = WRITE;
                end else if (!cram_oe_n) begin
                    // Latency 1 drives on this very edge; otherwise wait out
                    // lat_m1 cycles in READ_LAT.
                    if (lat_m1 == 4'd0) begin
                        dq_out_d = read_word;
                        dq_oe_d  = 1'b1;
                        state_d  = READ_DRIVE;
                    end else begin
                        cnt_d   = lat_m1;
                        wait_d  = 1'b1;
                        state_d = READ_LAT;
                    end
                end
            end
            WRITE: begin
                if (sel && !cram_we_n) begin
                    hold_data_d = cram_dq_in;
                    hold_ub_n_d = cram_ub_n;
                    hold_lb_n_d = cram_lb_n;
                end else begin
`ifdef PSRAM_RESPONDER_BCR_EN
                    mem_we = ~cre_q;
`else
                    mem_we = 1'b1;
`endif
                    wcnt_d = wcnt_q + 16'd1;
                    if (sel && !cram_adv_n) begin
                        latch_addr = 1'b1;
                        state_d    = ADDR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            READ_LAT: begin
                if (!sel) begin
                    wait_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == 4'd1) begin
                    wait_d   = 1'b0;
                    dq_out_d = read_word;
                    dq_oe_d  = 1'b1;
                    state_d  = READ_DRIVE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            READ_DRIVE: begin
                if (!sel || cram_oe_n) begin
                    dq_oe_d = 1'b0;
                    rcnt_d  = rcnt_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (latch_addr) begin
            addr_d = adv_addr[ADDR_WIDTH-1:0];
`ifdef PSRAM_RESPONDER_BCR_EN
            cre_d = cram_cre;
            if (cram_cre) bcr_d = adv_addr[15:0];
`endif
        end

        // ADV low is only a violation while a data phase is still running;
        // ADV on the closing edge of a write is a legal back-to-back start.
        err_d = err_q | (sel & (
                    (!cram_we_n && !cram_oe_n) ||
                    (state_q == WRITE      && !cram_adv_n && !cram_we_n) ||
                    (state_q == READ_DRIVE && !cram_adv_n && !cram_oe_n) ||
                    (state_q == WRITE      && !cram_oe_n)));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            hold_data_q <= '0;
            hold_ub_n_q <= 1'b1;
            hold_lb_n_q <= 1'b1;
            cnt_q       <= '0;
            wait_q      <= 1'b0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            err_q       <= 1'b0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
`ifdef PSRAM_RESPONDER_BCR_EN
            cre_q       <= 1'b0;
            bcr_q       <= BCR_RESET;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            hold_data_q <= hold_data_d;
            hold_ub_n_q <= hold_ub_n_d;
            hold_lb_n_q <= hold_lb_n_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            err_q       <= err_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
`ifdef PSRAM_RESPONDER_BCR_EN
            cre_q       <= cre_d;
            bcr_q       <= bcr_d;
`endif
        end
    end

    assign cram_dq_out  = dq_out_q;
    assign cram_dq_oe   = dq_oe_q;
    assign cram_wait    = WAIT_ACTIVE_HIGH ? wait_q : ~wait_q;
    assign protocol_err = err_q;
    assign write_count  = wcnt_q;
    assign read_count   = rcnt_q;

endmodule

// File: tb/tb_psram_responder.sv
// -----------------------------------------------------------------------------
// tb_psram_responder
// Directed bench for psram_responder: writes, byte-masked writes, read latency,
// address aliasing, READ_LAT abort, protocol errors and reset mid-read.
// Optional BCR checks run when PSRAM_RESPONDER_BCR_EN is defined.
// -----------------------------------------------------------------------------
module tb_psram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  cram_a;
    logic [15:0] cram_dq_in;
    logic [15:0] cram_dq_out;
    logic        cram_dq_oe;
    logic        cram_ce_n, cram_adv_n, cram_cre, cram_we_n, cram_oe_n;
    logic        cram_ub_n, cram_lb_n;
    logic        cram_wait;
    logic        protocol_err;
    logic [15:0] write_count, read_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_wc   = 0;
    int exp_rc   = 0;

    always #5 clk = ~clk;

    psram_responder #(
        .ADDR_WIDTH       (10),
        .READ_LATENCY     (3),
        .WAIT_ACTIVE_HIGH (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cram_a       (cram_a),
        .cram_dq_in   (cram_dq_in),
        .cram_dq_out  (cram_dq_out),
        .cram_dq_oe   (cram_dq_oe),
        .cram_ce_n    (cram_ce_n),
        .cram_adv_n   (cram_adv_n),
        .cram_cre     (cram_cre),
        .cram_we_n    (cram_we_n),
        .cram_oe_n    (cram_oe_n),
        .cram_ub_n    (cram_ub_n),
        .cram_lb_n    (cram_lb_n),
        .cram_wait    (cram_wait),
        .protocol_err (protocol_err),
        .write_count  (write_count),
        .read_count   (read_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        cram_ce_n  = 1'b1;
        cram_adv_n = 1'b1;
        cram_cre   = 1'b0;
        cram_we_n  = 1'b1;
        cram_oe_n  = 1'b1;
        cram_ub_n  = 1'b1;
        cram_lb_n  = 1'b1;
        cram_a     = '0;
        cram_dq_in = '0;
    endtask

    task automatic adv_phase(input logic [21:0] addr, input logic cre);
        cram_ce_n  = 1'b0;
        cram_adv_n = 1'b0;
        cram_cre   = cre;
        cram_a     = addr[21:16];
        cram_dq_in = addr[15:0];
        tick();
        cram_adv_n = 1'b1;
        cram_cre   = 1'b0;
    endtask

    // Controller timing: ADV one cycle, WE low five cycles, then deselect.
    task automatic do_write(input logic [21:0] addr, input logic [15:0] data,
                            input logic ub_n, input logic lb_n, input logic cre);
        adv_phase(addr, cre);
        cram_we_n  = 1'b0;
        cram_ub_n  = ub_n;
        cram_lb_n  = lb_n;
        cram_dq_in = data;
        repeat (5) tick();
        bus_idle();
        tick();
        exp_wc++;
        check("write_count", 32'(write_count), 32'(exp_wc));
    endtask

    task automatic do_read(input logic [21:0] addr, input logic [15:0] exp,
                           input int lat, input logic cre, input string tag);
        adv_phase(addr, cre);
        cram_oe_n = 1'b0;
        for (int k = 1; k < lat; k++) begin
            tick();
            check({tag, "_wait"}, 32'(cram_wait), 32'd1);
            check({tag, "_oe_early"}, 32'(cram_dq_oe), 32'd0);
        end
        tick();
        check({tag, "_oe"}, 32'(cram_dq_oe), 32'd1);
        check({tag, "_wait_off"}, 32'(cram_wait), 32'd0);
        check({tag, "_data"}, 32'(cram_dq_out), 32'(exp));
        bus_idle();
        tick();
        check({tag, "_oe_release"}, 32'(cram_dq_oe), 32'd0);
        exp_rc++;
        check({tag, "_read_count"}, 32'(read_count), 32'(exp_rc));
    endtask

    task automatic apply_reset();
        bus_idle();
        reset = 1'b1;
        repeat (2) tick();
        reset  = 1'b0;
        exp_wc = 0;
        exp_rc = 0;
        tick();
    endtask

    initial begin
        bus_idle();
        apply_reset();

        // Reset state
        check("rst_dq_oe",   32'(cram_dq_oe),   32'd0);
        check("rst_dq_out",  32'(cram_dq_out),  32'd0);
        check("rst_wait",    32'(cram_wait),    32'd0);
        check("rst_err",     32'(protocol_err), 32'd0);
        check("rst_wcount",  32'(write_count),  32'd0);
        check("rst_rcount",  32'(read_count),   32'd0);

        // Full write to 22'h2F0B00 -> index 10'h300, then read back.
        do_write(22'h2F0B00, 16'hCCBB, 1'b0, 1'b0, 1'b0);
        do_read(22'h2F0B00, 16'hCCBB, 3, 1'b0, "rd_ccbb");

        // Address aliasing: 22'h000300 maps to the same word.
        do_read(22'h000300, 16'hCCBB, 3, 1'b0, "rd_alias");

        // Lower-byte-only write through another alias (0x700 mod 1024 = 0x300).
        do_write(22'h000700, 16'h1234, 1'b1, 1'b0, 1'b0);
        do_read(22'h2F0B00, 16'hCC34, 3, 1'b0, "rd_lb_mask");

        // Upper-byte-only write over a full word at another index.
        do_write(22'h000001, 16'hA5A5, 1'b0, 1'b0, 1'b0);
        do_write(22'h000001, 16'h5A00, 1'b0, 1'b1, 1'b0);
        do_read(22'h000001, 16'h5AA5, 3, 1'b0, "rd_ub_mask");
        check("err_clean", 32'(protocol_err), 32'd0);

        // Deselect during READ_LAT aborts without driving or counting.
        adv_phase(22'h2F0B00, 1'b0);
        cram_oe_n = 1'b0;
        tick();
        check("abort_wait", 32'(cram_wait), 32'd1);
        bus_idle();
        tick();
        check("abort_wait_off", 32'(cram_wait), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check("abort_no_oe", 32'(cram_dq_oe), 32'd0);
            tick();
        end
        check("abort_rcount", 32'(read_count), 32'(exp_rc));
        check("abort_wcount", 32'(write_count), 32'(exp_wc));
        do_read(22'h2F0B00, 16'hCC34, 3, 1'b0, "rd_after_abort");

        // WE and OE low together: sticky error, transaction still completes.
        adv_phase(22'h000005, 1'b0);
        cram_we_n  = 1'b0;
        cram_oe_n  = 1'b0;
        cram_dq_in = 16'hFFFF;
        tick();
        check("err_we_oe", 32'(protocol_err), 32'd1);
        cram_oe_n = 1'b1;
        tick();
        bus_idle();
        tick();
        exp_wc++;
        check("err_write_count", 32'(write_count), 32'(exp_wc));
        do_read(22'h000300, 16'hCC34, 3, 1'b0, "rd_after_err");
        check("err_sticky", 32'(protocol_err), 32'd1);

        // Reset while driving read data: dq_oe drops without a clock edge.
        adv_phase(22'h2F0B00, 1'b0);
        cram_oe_n = 1'b0;
        repeat (3) tick();
        check("rd_drive_oe", 32'(cram_dq_oe), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_oe", 32'(cram_dq_oe), 32'd0);
        check("async_rst_err", 32'(protocol_err), 32'd0);
        bus_idle();
        tick();
        reset  = 1'b0;
        exp_wc = 0;
        exp_rc = 0;
        tick();
        check("post_rst_rcount", 32'(read_count), 32'd0);
        do_read(22'h2F0B00, 16'hCC34, 3, 1'b0, "rd_after_rst");

        // ADV low during the write data phase: error, write still commits.
        adv_phase(22'h000010, 1'b0);
        cram_we_n  = 1'b0;
        cram_ub_n  = 1'b0;
        cram_lb_n  = 1'b0;
        cram_dq_in = 16'h0F0F;
        tick();
        check("err_pre_adv", 32'(protocol_err), 32'd0);
        cram_adv_n = 1'b0;
        tick();
        check("err_adv_in_write", 32'(protocol_err), 32'd1);
        cram_adv_n = 1'b1;
        tick();
        bus_idle();
        tick();
        exp_wc++;
        check("adv_err_wcount", 32'(write_count), 32'(exp_wc));
        do_read(22'h000010, 16'h0F0F, 3, 1'b0, "rd_after_adv_err");

`ifdef PSRAM_RESPONDER_BCR_EN
        apply_reset();
        do_write(22'h001800, 16'h0000, 1'b1, 1'b1, 1'b1);
        do_read(22'h2F0B00, 16'hCC34, 3, 1'b0, "bcr_array_rd");
        do_read(22'h001800, 16'h1800, 3, 1'b1, "bcr_cre_rd");
        // Latency field 1 -> data on the OE-sampling edge's successor count of 1.
        do_write(22'h000800, 16'h0000, 1'b1, 1'b1, 1'b1);
        do_read(22'h2F0B00, 16'hCC34, 1, 1'b0, "bcr_lat1_rd");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/psram_responder.md
Name: psram_responder

Overview:
- Synthesizable device-side model of one CellularRAM bank, answering the PSRAM controller's asynchronous multiplexed-address protocol.
- Used in simulation benches and in loopback builds, where it stands in for the physical chip.
- Latches the address on ADV and services a write (WE) or a read (OE) from a small internal word array.
- Raises a sticky flag on any protocol violation.

Parameters:
- ADDR_WIDTH, 10, log2 of the number of 16-bit words in the backing array; the latched 22-bit address is truncated to its low ADDR_WIDTH bits.
- READ_LATENCY, 3, number of clk cycles from OE low being sampled to dq_oe rising; legal range 1..15.
- WAIT_ACTIVE_HIGH, 1, polarity of cram_wait.

Ports:
- clk  in  1  system clock; the controller's clock, with all cram_* inputs sampled on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cram_a  in  6  high address bits [21:16].
- cram_dq_in  in  16  DQ bus as driven by the controller.
- cram_dq_out  out  16  read data toward the DQ bus.
- cram_dq_oe  out  1  high = responder drives DQ; the bench resolves the inout.
- cram_ce_n  in  1  chip enable for this bank.
- cram_adv_n  in  1  address valid, active low.
- cram_cre  in  1  configuration register enable.
- cram_we_n  in  1  write enable, active low.
- cram_oe_n  in  1  output enable, active low.
- cram_ub_n  in  1  upper byte enable, active low.
- cram_lb_n  in  1  lower byte enable, active low.
- cram_wait  out  1  busy indication during read latency.
- protocol_err  out  1  sticky protocol violation flag, cleared only by reset.
- write_count  out  16  number of committed writes, wrapping.
- read_count  out  16  number of completed reads, wrapping.

Behaviour:
- Reset values: cram_dq_out=0, cram_dq_oe=0, cram_wait=inactive, protocol_err=0, both counters=0, state=IDLE. The array is not cleared.
- IDLE:
  - On a sampled edge with ce_n=0 and adv_n=0: latch addr={cram_a, cram_dq_in}, go to ADDR.
  - adv_n=0 while ce_n=1 is ignored.
- ADDR:
  - Stays while adv_n=0; further samples overwrite the latched address.
  - Once adv_n=1: if we_n=0 go to WRITE; if oe_n=0 go to READ_LAT; if both are still high, remain in ADDR.
- WRITE:
  - Every cycle with we_n=0, sample dq_in, ub_n and lb_n into a holding register.
  - On the first cycle with we_n=1 or ce_n=1, commit the holding register to mem[addr] with byte masking: ub_n=0 writes [15:8], lb_n=0 writes [7:0].
  - The commit increments write_count and returns to IDLE (or to ADDR if ce_n=0 and adv_n=0 on that same edge).
- READ_LAT:
  - Counter loads READ_LATENCY-1 and cram_wait is active.
  - Counter expiry → READ_DRIVE: cram_dq_out=mem[addr], cram_dq_oe=1, cram_wait inactive.
- READ_DRIVE:
  - Holds the data while oe_n=0 and ce_n=0.
  - On oe_n=1 or ce_n=1: dq_oe=0 on the next edge, read_count increments, go to IDLE.
- ce_n rising in ADDR or READ_LAT aborts to IDLE. Nothing is committed and no counter changes.
- protocol_err sets on any of:
  - we_n=0 and oe_n=0 in the same sample;
  - adv_n=0 while in WRITE or READ_DRIVE;
  - oe_n=0 sampled during WRITE.
- After an error the transaction continues.
- Array reads are combinational on the latched index; array writes are synchronous.
- Address wrap: addr beyond the array depth aliases modulo 2^ADDR_WIDTH.
- Reset mid-transaction returns to IDLE with dq_oe low within the same cycle.
- When cram_cre=1 at the ADV sample, behaviour depends on the optional feature (see Optional Feature).

Optional Feature:
- Macro: PSRAM_RESPONDER_BCR_EN.
- When defined, cram_cre=1 at the ADV sample causes the latched address to be written into a 16-bit BCR register. BCR reset value is 16'h9D1F.
- BCR[13:11] overrides READ_LATENCY as the read latency; value 0 means 8.
- A read with cre=1 returns BCR in place of mem[addr].
- When undefined, cram_cre is ignored, cre transactions access the array normally, and latency is fixed at READ_LATENCY.

Decomposition:
- Shared package psram_pkg holds the state enum (IDLE, ADDR, WRITE, READ_LAT, READ_DRIVE), the BCR reset constant, and the BCR latency field indices.
- One sub-module: psram_word_array, a byte-masked single-port array with a synchronous write and a combinational read.

Test Plan:
- Write 16'hCCBB to 22'h2F0B00 using the controller's timing (ADV 1 cycle, WE low 5 cycles) → mem[10'h300]=16'hCCBB, write_count=1.
- Read back the same address with oe_n low → cram_wait is active for 2 cycles, then dq_oe=1 with dq_out=16'hCCBB on the 3rd cycle after OE low. read_count=1 after oe_n rises.
- Write 16'h1234 with ub_n=1, lb_n=0 over a stored 16'hCCBB → read returns 16'hCC34.
- Raise ce_n during READ_LAT → dq_oe never asserts, read_count unchanged, state=IDLE. Drive we_n=0 and oe_n=0 together → protocol_err=1 and stays set until reset.
- Assert reset while in READ_DRIVE → dq_oe=0 immediately; a subsequent read of 10'h300 still returns the previously written data.
- With PSRAM_RESPONDER_BCR_EN defined: cre write of address 22'h00_1800 (BCR[13:11]=3) then an array read → dq_oe rises 3 cycles after OE low; a cre read returns 16'h1800.
